letreiro_scroll: RTL and testbench
==================================

Name: letreiro_scroll

Overview:
- Producer side of the 4-bit character-code interface that feeds the per-digit 7-segment decoders.
- Holds the team message "PAYSANDU" plus trailing blanks as a circular sequence. Drives six character codes, one per HEX display, and scrolls the message one position every TICKS_PER_STEP enabled clocks.
- Sits between the board clock and the six decoder instances on HEX5..HEX0.

Parameters:
- TICKS_PER_STEP, default 25000000: enabled clock cycles per scroll step (0.5 s at 50 MHz). Legal range is 1 or more; 1 means one step per enabled cycle.
- GAP, default 2: number of blank codes appended after "PAYSANDU". Legal range 0..8. Sequence length L = 8 + GAP.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scrolling advances only while high.
- restart  in  1  synchronous request to return to start position; acts like reset on pos and cnt.
- codes  out  24  character codes; codes[4i+3:4i] drives HEX i; HEX5 is leftmost.
- step  out  1  one-cycle pulse on each scroll advance.
- wrap  out  1  one-cycle pulse when the step returns pos to 0 (or from 0 to L-1, see Optional Feature).

Behaviour:
- Sequence seq[0..L-1]:
  - seq[0..7] = 0,1,2,3,4,5,6,7, the codes for P,A,Y,S,A,N,D,U.
  - seq[8..L-1] = 8, the blank code.
  - No codes above 8 are ever emitted.
- State registers:
  - pos, range 0..L-1, width $clog2(L).
  - cnt, range 0..TICKS_PER_STEP-1, width max(1, $clog2(TICKS_PER_STEP)).
  - step and wrap are registered.
- Display mapping: HEX(5-k) = seq[(pos+k) mod L] for k=0..5. codes is a combinational decode of registered pos, so it changes on the same edge as pos. Modulo is computed by compare-and-subtract, not a divider.
- reset (highest priority): pos=0, cnt=0, step=0, wrap=0. codes = 24'h012345, i.e. "PAYSAN".
- restart=1 (ranks below reset, above everything else): same register effect as reset. Any tick in that same cycle is discarded; no step or wrap pulse.
- enable=0: cnt and pos hold; step and wrap are 0 next cycle.
- enable=1 and cnt < TICKS_PER_STEP-1: cnt increments; step=0.
- enable=1 and cnt == TICKS_PER_STEP-1 (a tick):
  - cnt goes to 0.
  - pos advances: pos+1, with L-1 going to 0.
  - step=1 for exactly one cycle, aligned with the new pos.
  - wrap=1 in the same cycle if the new pos is 0.
- Latency: the first step occurs TICKS_PER_STEP enabled cycles after reset or restart release.
- Deasserting enable mid-count preserves the partial count; reasserting resumes without loss.
- GAP=0: the sequence wraps directly U→P with no blank.
- No handshake back-pressure; the consumer decoders are combinational.

Optional Feature:
- Macro SCROLL_DIR_EN.
- When defined:
  - Adds input port dir (1 bit), placed after restart.
  - dir=0: scroll left, pos increments as above.
  - dir=1: scroll right; on a tick, pos decrements, with 0 going to L-1.
  - wrap pulses when the new pos is L-1 on a right step.
  - dir is sampled on the tick cycle only. Changing dir does not reset cnt.
- When undefined: no dir port; behaviour is left-scroll only, identical to dir=0.

Test Plan:
All scenarios use TICKS_PER_STEP=4, GAP=2, so L=10.
- Reset for 2 cycles, then enable=1: codes = 24'h012345 for 4 cycles. On the 4th enabled edge, step=1 and codes = 24'h123456. Next cycle step=0.
- Run 5 steps from reset: codes = 24'h567880. At 9 steps: codes = 24'h801234. At 10 steps: codes = 24'h012345, with wrap=1 and step=1 in the same cycle.
- enable=1 for 2 cycles, enable=0 for 10 cycles, enable=1 for 2 cycles: step fires at the 4th enabled cycle only. codes stays 24'h012345 through the pause.
- Run to pos=3, pulse restart in the same cycle a tick would occur: codes = 24'h012345, no step or wrap pulse. The next step occurs 4 enabled cycles later.
- Assert reset mid-count at pos=7, whose codes are 24'h788012: next cycle codes = 24'h012345, and step, wrap and cnt are all 0.
- SCROLL_DIR_EN defined, dir=1 from reset:
  - First tick: codes = 24'h801234 with wrap=1.
  - Second tick: codes = 24'h880123.
  - Set dir=0, next tick: codes = 24'h801234.

Source files
------------

// File: rtl/letreiro_scroll.sv
// rtl/letreiro_scroll.sv - scrolls "PAYSANDU" plus GAP blanks across six 4-bit HEX character codes
// Optional SCROLL_DIR_EN adds a dir input for right scrolling.
module letreiro_scroll #(
  parameter int TICKS_PER_STEP = 25000000,
  parameter int GAP            = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
`ifdef SCROLL_DIR_EN
  input  logic        dir,
`endif
  output logic [23:0] codes,
  output logic        step,
  output logic        wrap
);

  localparam int L  = 8 + GAP;
  localparam int PW = $clog2(L);
  localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(L - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_STEP - 1);

  logic [PW-1:0] pos;
  logic [PW-1:0] pos_next;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          dir_right;
  logic          wrap_hit;

`ifdef SCROLL_DIR_EN
  assign dir_right = dir;
`else
  assign dir_right = 1'b0;
`endif

  assign tick = enable && (cnt == CNT_LAST);

  always_comb begin
    pos_next = pos;
    wrap_hit = 1'b0;
    if (dir_right) begin
      pos_next = (pos == '0) ? POS_LAST : pos - PW'(1);
      wrap_hit = (pos_next == POS_LAST);
    end else begin
      pos_next = (pos == POS_LAST) ? '0 : pos + PW'(1);
      wrap_hit = (pos_next == '0);
    end
  end

  // restart shares reset's register effect, so a coincident tick is simply dropped
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pos  <= '0;
      cnt  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      pos  <= pos_next;
      step <= 1'b1;
      wrap <= wrap_hit;
    end else begin
      if (enable) begin
        cnt <= cnt + CW'(1);
      end
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // pos+k < 2L always holds, so one conditional subtract implements the modulo
  always_comb begin
    codes = '0;
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = int'(pos) + k;
      if (idx >= L) begin
        idx = idx - L;
      end
      codes[4*(5-k) +: 4] = (idx < 8) ? 4'(idx) : 4'd8;
    end
  end

endmodule

// File: tb/tb_letreiro_scroll.sv
// tb/tb_letreiro_scroll.sv - directed table-driven bench for letreiro_scroll
module tb_letreiro_scroll;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, enable = 1'b0, restart = 1'b0, dir = 1'b0;
  logic [23:0] codes;
  logic        step, wrap;

  logic        reset2 = 1'b1, enable2 = 1'b0, restart2 = 1'b0, dir2 = 1'b0;
  logic [23:0] codes2;
  logic        step2, wrap2;

  letreiro_scroll #(.TICKS_PER_STEP(4), .GAP(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
`ifdef SCROLL_DIR_EN
    .dir(dir),
`endif
    .codes(codes), .step(step), .wrap(wrap)
  );

  letreiro_scroll #(.TICKS_PER_STEP(1), .GAP(0)) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2), .restart(restart2),
`ifdef SCROLL_DIR_EN
    .dir(dir2),
`endif
    .codes(codes2), .step(step2), .wrap(wrap2)
  );

  typedef struct {
    logic        r;
    logic        e;
    logic        rs;
    logic [23:0] c;
    logic        s;
    logic        w;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Expected codes by position, L=10 (seq 0..7,8,8) and L=8 (seq 0..7)
  logic [23:0] p10[10] = '{24'h012345, 24'h123456, 24'h234567, 24'h345678, 24'h456788,
                           24'h567880, 24'h678801, 24'h788012, 24'h880123, 24'h801234};
  logic [23:0] p8[8]   = '{24'h012345, 24'h123456, 24'h234567, 24'h345670,
                           24'h456701, 24'h567012, 24'h670123, 24'h701234};

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic rs, input logic [23:0] c,
                     input logic s, input logic w, input string tag);
    reset = r; enable = e; restart = rs;
    @(posedge clk); #1;
    chk({tag, " codes"}, codes, c);
    chk({tag, " step"}, {23'd0, step}, {23'd0, s});
    chk({tag, " wrap"}, {23'd0, wrap}, {23'd0, w});
  endtask

  function automatic void add(input logic r, input logic e, input logic rs,
                              input logic [23:0] c, input logic s, input logic w);
    vecs.push_back('{r, e, rs, c, s, w});
  endfunction

  initial begin
    int p;
    logic s;

    // Segment A: reset, then 40 enabled cycles = 10 steps ending in a wrap
    add(1, 0, 0, p10[0], 0, 0);
    add(1, 0, 0, p10[0], 0, 0);
    for (int c = 1; c <= 40; c++) begin
      p = (c / 4) % 10;
      s = (c % 4 == 0);
      add(0, 1, 0, p10[p], s, s && (p == 0));
    end
    // Segment B: enable pause preserves partial count
    add(1, 0, 0, p10[0], 0, 0);
    add(0, 1, 0, p10[0], 0, 0);
    add(0, 1, 0, p10[0], 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, p10[0], 0, 0);
    add(0, 1, 0, p10[0], 0, 0);
    add(0, 1, 0, p10[1], 1, 0);
    add(0, 0, 0, p10[1], 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].rs, vecs[i].c, vecs[i].s, vecs[i].w,
          $sformatf("vec%0d", i));
    end

    // Restart on the cycle a tick would occur
    cyc(1, 0, 0, p10[0], 0, 0, "rst_pre");
    for (int c = 1; c <= 15; c++) cyc(0, 1, 0, p10[c / 4], (c % 4 == 0), 0, $sformatf("rs_run%0d", c));
    cyc(0, 1, 1, p10[0], 0, 0, "restart_tick");
    for (int c = 1; c <= 3; c++) cyc(0, 1, 0, p10[0], 0, 0, $sformatf("rs_after%0d", c));
    cyc(0, 1, 0, p10[1], 1, 0, "rs_first_step");

    // Reset mid-count at pos 7
    cyc(1, 0, 0, p10[0], 0, 0, "mid_pre");
    for (int c = 1; c <= 30; c++) cyc(0, 1, 0, p10[c / 4], (c % 4 == 0), 0, $sformatf("mid_run%0d", c));
    cyc(1, 1, 0, p10[0], 0, 0, "mid_reset");
    for (int c = 1; c <= 3; c++) cyc(0, 1, 0, p10[0], 0, 0, $sformatf("mid_after%0d", c));
    cyc(0, 1, 0, p10[1], 1, 0, "mid_first_step");

`ifdef SCROLL_DIR_EN
    dir = 1'b1;
    cyc(1, 0, 0, p10[0], 0, 0, "dir_rst");
    for (int c = 1; c <= 3; c++) cyc(0, 1, 0, p10[0], 0, 0, "dir_a");
    cyc(0, 1, 0, p10[9], 1, 1, "dir_tick1");
    for (int c = 1; c <= 3; c++) cyc(0, 1, 0, p10[9], 0, 0, "dir_b");
    cyc(0, 1, 0, p10[8], 1, 0, "dir_tick2");
    dir = 1'b0;
    for (int c = 1; c <= 3; c++) cyc(0, 1, 0, p10[8], 0, 0, "dir_c");
    cyc(0, 1, 0, p10[9], 1, 0, "dir_tick3");
    cyc(1, 0, 0, p10[0], 0, 0, "dir_end");
`endif

    // GAP=0, TICKS_PER_STEP=1: a step every enabled cycle, wrap U->P directly
    reset2 = 1'b1; enable2 = 1'b1;
    @(posedge clk); #1;
    chk("g0 reset codes", codes2, 24'h012345);
    chk("g0 reset step", {23'd0, step2}, 24'd0);
    reset2 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      chk($sformatf("g0 codes%0d", c), codes2, p8[c % 8]);
      chk($sformatf("g0 step%0d", c), {23'd0, step2}, 24'd1);
      chk($sformatf("g0 wrap%0d", c), {23'd0, wrap2}, {23'd0, (c % 8 == 0)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
